// File: rtl/hidden_weight_update.sv
// hidden_weight_update
// Applies the gradient step to the input->hidden weight bank, one weight per
// cycle: w <= w - sign(delta0[h]) * ((delta0[h] * x[i]) >> LR_SHIFT).
// Weights are 10-bit signed-magnitude (bit9 sign, [8:0] magnitude).
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   start                one-cycle request to run an update pass
//   delta0, sign0        packed delta magnitudes / signs (1 = negative)
//   x_in                 packed unsigned input features
//   wr_en/wr_addr/wr_data  host weight write (ignored while busy)
//   rd_addr/rd_data      host read, registered, 1-cycle latency
//   busy, done           pass in progress / one-cycle completion pulse
//   sat_count            saturation event counter
//
// Optional feature: define HWU_SAT_CNT_EN to build the saturation counter;
// otherwise sat_count is tied to zero.
//
// state   | meaning
// IDLE    | waiting for start, host writes allowed
// CAPTURE | latch delta0/sign0/x_in, reset indices
// RUN     | update weight h*N_IN+i, one per cycle
// DONE    | pulse done, return to IDLE
module hidden_weight_update #(
    parameter int N_HID    = 5,
    parameter int N_IN     = 4,
    parameter int LR_SHIFT = 6,
    parameter int AW       = $clog2(N_HID * N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [10*N_HID-1:0]   delta0,
    input  logic [N_HID-1:0]      sign0,
    input  logic [10*N_IN-1:0]    x_in,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [9:0]            wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [9:0]            rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            sat_count
);

    localparam int NW = N_HID * N_IN;
    localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_RUN, S_DONE} state_t;

    state_t             state_q;
    logic [9:0]         w_q     [NW];
    logic [9:0]         delta_q [N_HID];
    logic [9:0]         x_q     [N_IN];
    logic [N_HID-1:0]   sign_q;
    logic [HW-1:0]      h_q;
    logic [IW-1:0]      i_q;
    logic [AW-1:0]      addr_q;
    logic [9:0]         rd_data_q;
    logic               busy_q;
    logic               done_q;

    logic [9:0]         cur_w_d;
    logic [19:0]        prod_d;
    logic [19:0]        shifted_d;
    logic [8:0]         term_d;
    logic signed [11:0] w_tc_d;
    logic signed [11:0] sum_d;
    logic [9:0]         new_w_d;
`ifdef HWU_SAT_CNT_EN
    logic [7:0]         sat_cnt_q;
    logic               sat_d;
`endif

    // Per-weight datapath: decode to two's complement, step, clamp, re-encode.
    always_comb begin
        cur_w_d   = w_q[addr_q];
        prod_d    = {10'b0, delta_q[h_q]} * {10'b0, x_q[i_q]};
        shifted_d = prod_d >> LR_SHIFT;
        term_d    = (shifted_d > 20'd511) ? 9'd511 : 9'(shifted_d);
        // -0 decodes to 0 because negating a zero magnitude is still zero.
        w_tc_d    = cur_w_d[9] ? -$signed({3'b000, cur_w_d[8:0]})
                               :  $signed({3'b000, cur_w_d[8:0]});
        sum_d     = sign_q[h_q] ? (w_tc_d + $signed({3'b000, term_d}))
                                : (w_tc_d - $signed({3'b000, term_d}));
        if (sum_d > 12'sd511) begin
            new_w_d = {1'b0, 9'd511};
        end else if (sum_d < -12'sd511) begin
            new_w_d = {1'b1, 9'd511};
        end else if (sum_d < 12'sd0) begin
            new_w_d = {1'b1, 9'(-sum_d)};
        end else begin
            new_w_d = {1'b0, 9'(sum_d)};
        end
`ifdef HWU_SAT_CNT_EN
        sat_d = (sum_d > 12'sd511) || (sum_d < -12'sd511);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            for (int k = 0; k < NW; k++) w_q[k] <= 10'h000;
            for (int k = 0; k < N_HID; k++) delta_q[k] <= 10'h000;
            for (int k = 0; k < N_IN; k++) x_q[k] <= 10'h000;
            sign_q    <= '0;
            h_q       <= '0;
            i_q       <= '0;
            addr_q    <= '0;
            rd_data_q <= 10'h000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef HWU_SAT_CNT_EN
            sat_cnt_q <= 8'h00;
`endif
        end else begin
            done_q <= 1'b0;
            rd_data_q <= (32'(rd_addr) < NW) ? w_q[rd_addr] : 10'h000;
            // Host writes are blocked for the whole pass so RUN owns the bank.
            if (wr_en && !busy_q && (32'(wr_addr) < NW)) begin
                w_q[wr_addr] <= wr_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    for (int k = 0; k < N_HID; k++) delta_q[k] <= delta0[10*k +: 10];
                    for (int k = 0; k < N_IN; k++) x_q[k] <= x_in[10*k +: 10];
                    sign_q  <= sign0;
                    h_q     <= '0;
                    i_q     <= '0;
                    addr_q  <= '0;
`ifdef HWU_SAT_CNT_EN
                    sat_cnt_q <= 8'h00;
`endif
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    w_q[addr_q] <= new_w_d;
`ifdef HWU_SAT_CNT_EN
                    if (sat_d && (sat_cnt_q != 8'hFF)) sat_cnt_q <= sat_cnt_q + 8'd1;
`endif
                    if (i_q == IW'(N_IN - 1)) begin
                        i_q <= '0;
                        h_q <= h_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                    addr_q <= addr_q + 1'b1;
                    if (addr_q == AW'(NW - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef HWU_SAT_CNT_EN
    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 8'h00;
`endif

endmodule

// File: tb/tb_hidden_weight_update.sv
module tb_hidden_weight_update;

    localparam int N_HID = 5;
    localparam int N_IN  = 4;
    localparam int NW    = N_HID * N_IN;
    localparam int AW    = 5;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [10*N_HID-1:0] delta0;
    logic [N_HID-1:0]    sign0;
    logic [10*N_IN-1:0]  x_in;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [9:0]          wr_data;
    logic [AW-1:0]       rd_addr;
    logic [9:0]          rd_data;
    logic                busy;
    logic                done;
    logic [7:0]          sat_count;

    int n_tests;
    int n_fail;
    int model_w [NW];
    int model_sat;

    hidden_weight_update dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .delta0    (delta0),
        .sign0     (sign0),
        .x_in      (x_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int dec(input logic [9:0] sm);
        return sm[9] ? -int'(sm[8:0]) : int'(sm[8:0]);
    endfunction

    function automatic logic [9:0] enc(input int v);
        logic [8:0] m;
        if (v < 0) begin
            m = 9'(-v);
            return {1'b1, m};
        end
        m = 9'(v);
        return {1'b0, m};
    endfunction

    // Reference pass: plain integer arithmetic over the spec's update rule.
    task automatic model_pass(input logic [10*N_HID-1:0] d, input logic [N_HID-1:0] s,
                              input logic [10*N_IN-1:0] x);
        model_sat = 0;
        for (int h = 0; h < N_HID; h++) begin
            for (int i = 0; i < N_IN; i++) begin
                int t;
                int sum;
                t = (int'(d[10*h +: 10]) * int'(x[10*i +: 10])) / 64;
                if (t > 511) t = 511;
                sum = s[h] ? model_w[h*N_IN+i] + t : model_w[h*N_IN+i] - t;
                if (sum > 511 || sum < -511) begin
                    if (model_sat < 255) model_sat++;
                    sum = (sum > 0) ? 511 : -511;
                end
                model_w[h*N_IN+i] = sum;
            end
        end
    endtask

    task automatic host_write(input int a, input logic [9:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        if (a < NW) model_w[a] = dec(v);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [9:0] v);
        @(negedge clk);
        rd_addr = AW'(a);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic check_bank(input string tag);
        logic [9:0] v;
        for (int a = 0; a < NW; a++) begin
            host_read(a, v);
            check($sformatf("%s_w%0d", tag, a), 32'(v), 32'(enc(model_w[a])));
        end
    endtask

    task automatic run_pass(input string tag, input logic [10*N_HID-1:0] d,
                            input logic [N_HID-1:0] s, input logic [10*N_IN-1:0] x,
                            input bit disturb, input bit wr_with_start,
                            input int wa, input logic [9:0] wd);
        int done_cnt;
        int done_at;
        int busy_err;
        @(negedge clk);
        delta0 = d; sign0 = s; x_in = x; start = 1'b1;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd;
            model_w[wa] = dec(wd);
        end
        model_pass(d, s, x);
        done_cnt = 0; done_at = 0; busy_err = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (n == 2) begin
                delta0 = {$urandom, $urandom};
                sign0  = N_HID'($urandom);
                x_in   = {$urandom, $urandom};
            end
            if (disturb && n == 8) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 10'($urandom);
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (busy !== ((n >= 1) && (n <= 21))) busy_err++;
        end
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_latency"}, 32'(done_at), 32'd22);
        check({tag, "_busy_profile"}, 32'(busy_err), 32'd0);
`ifdef HWU_SAT_CNT_EN
        check({tag, "_sat_count"}, 32'(sat_count), 32'(model_sat));
`else
        check({tag, "_sat_count"}, 32'(sat_count), 32'd0);
`endif
        check_bank(tag);
    endtask

    function automatic logic [10*N_HID-1:0] rand_delta();
        logic [10*N_HID-1:0] v;
        for (int h = 0; h < N_HID; h++) v[10*h +: 10] = 10'($urandom);
        return v;
    endfunction

    function automatic logic [10*N_IN-1:0] rand_x();
        logic [10*N_IN-1:0] v;
        for (int i = 0; i < N_IN; i++) v[10*i +: 10] = 10'($urandom_range(0, 255));
        return v;
    endfunction

    initial begin
        logic [9:0] v;
        logic [10*N_HID-1:0] d;
        logic [10*N_IN-1:0] x;
        int done_cnt;
        n_tests = 0; n_fail = 0;
        for (int a = 0; a < NW; a++) model_w[a] = 0;
        rst_n = 1'b0; start = 1'b0; delta0 = '0; sign0 = '0; x_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sat", 32'(sat_count), 32'd0);
        check("reset_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;

        // Directed pass covering basic step, -0 input, zero crossing, saturation.
        host_write(0, 10'h00A);
        host_write(5, 10'h200);
        host_write(8, 10'h010);
        host_write(19, 10'h3F4);
        host_write(25, 10'h155);
        host_read(25, v);
        check("oob_read", 32'(v), 32'd0);
        d = '0; d[9:0] = 10'd64; d[19:10] = 10'd64; d[29:20] = 10'd64; d[49:40] = 10'd1023;
        x = '0; x[9:0] = 10'd16; x[19:10] = 10'd16; x[39:30] = 10'd1023;
        run_pass("dir", d, 5'b00010, x, 1'b0, 1'b0, 0, 10'h0);
        host_read(0, v);  check("basic_step", 32'(v), 32'h206);
        host_read(5, v);  check("neg_delta", 32'(v), 32'h010);
        host_read(8, v);  check("zero_cross", 32'(v), 32'h000);
        host_read(19, v); check("saturate", 32'(v), 32'h3FF);

        // Randomized passes against the reference model.
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < NW; a++) host_write(a, 10'($urandom));
            run_pass($sformatf("rnd%0d", p), rand_delta(), N_HID'($urandom), rand_x(),
                     1'b0, 1'b0, 0, 10'h0);
        end

        // Mid-RUN start and write must be ignored.
        run_pass("disturb", rand_delta(), N_HID'($urandom), rand_x(), 1'b1, 1'b0, 0, 10'h0);

        // Write in the same IDLE cycle as start feeds the pass.
        run_pass("wr_start", rand_delta(), N_HID'($urandom), rand_x(), 1'b0, 1'b1,
                 6, 10'h1F0);

        // Reset during RUN at index 7.
        @(negedge clk);
        delta0 = rand_delta(); sign0 = N_HID'($urandom); x_in = rand_x(); start = 1'b1;
        repeat (9) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_busy_after", 32'(busy), 32'd0);
        for (int a = 0; a < NW; a++) model_w[a] = 0;
        check_bank("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hidden_weight_update.md
Name: hidden_weight_update

Overview:
- Consumes the hidden-layer error terms (delta0 magnitudes + sign0 bits) from the hidden-neuron delta stage. Applies the gradient step to the input->hidden weight bank: w <= w - sign(delta0[h]) * ((delta0[h] * x[i]) >> LR_SHIFT).
- Owns the weight register bank, updated serially, one weight per cycle. Start/busy/done handshake to the training sequencer.
- Host-side read/write port for weight init and readback.

Parameters:
- N_HID, 5, hidden neurons (matches delta0/sign0 width).
- N_IN, 4, input features per hidden neuron.
- LR_SHIFT, 6, learning rate as right shift of the 20-bit product.
- AW, $clog2(N_HID*N_IN), weight address width (5 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to run an update pass.
- delta0  in  10*N_HID  packed unsigned delta magnitudes; neuron h at [10h+9:10h].
- sign0  in  N_HID  delta sign per neuron; 1 = negative.
- x_in  in  10*N_IN  packed unsigned input features; feature i at [10i+9:10i].
- wr_en  in  1  host weight write strobe.
- wr_addr  in  AW  host write address; addr = h*N_IN + i.
- wr_data  in  10  signed-magnitude weight: bit9 sign, [8:0] magnitude.
- rd_addr  in  AW  host read address.
- rd_data  out  10  registered read data.
- busy  out  1  high from capture through the last update.
- done  out  1  one-cycle pulse after the last weight is written.
- sat_count  out  8  saturation event count (optional feature).

Behaviour:
- Reset: all weights 10'h000; rd_data=0, busy=0, done=0, sat_count=0; FSM=IDLE; index counters 0.
- FSM states:
  - IDLE: on start, go to CAPTURE.
  - CAPTURE: 1 cycle. Latch delta0, sign0, x_in into internal registers. Set busy=1. Set h=0, i=0. Go to RUN.
  - RUN: one weight per cycle at addr h*N_IN+i. i wraps at N_IN-1 and increments h. After addr N_HID*N_IN-1, go to DONE.
  - DONE: 1 cycle. done=1, busy=0. Go to IDLE.
- Latency: start at cycle T gives done at T+2+N_HID*N_IN (T+22 at defaults).
- Per-weight arithmetic:
  - prod = delta_mag[h] * x[i] (20-bit unsigned).
  - term = prod >> LR_SHIFT, clipped to 511.
  - Convert w to 11-bit two's complement; a sign-magnitude -0 (10'h200) reads as 0.
  - sum = w - term if sign0[h]=0, else w + term.
  - Saturate sum to [-511, +511]. Convert back to signed-magnitude; zero is always encoded 10'h000.
- Inputs are sampled only in CAPTURE; changes during RUN have no effect.
- start while busy or in DONE: ignored, no queuing.
- wr_en while busy=1: ignored (weight bank protected). In IDLE: write takes effect next edge.
- wr_en in the same cycle as start in IDLE: the write takes effect; the pass uses the written value.
- rd_data <= weight[rd_addr] every cycle, 1-cycle latency. During RUN it may return pre- or post-update values. Out-of-range rd_addr returns 0; out-of-range wr_addr is ignored.
- rst_n asserted mid-pass: immediate return to reset state, including a weight bank clear. The partial pass is lost; no done pulse.

Optional Feature:
- Macro HWU_SAT_CNT_EN.
- Defined: sat_count increments on each RUN cycle whose sum is clamped to ±511. It sticks at 255, is cleared in CAPTURE, and holds after DONE.
- Undefined: sat_count tied to 8'h00; no counter logic.

Test Plan:
- Basic step: w[0]=10'h00A (+10), delta0[0]=64, sign0[0]=0, x[0]=16, LR_SHIFT=6 -> term=16, w[0]=10'h206 (-6); done exactly 22 cycles after start.
- Negative delta: w[5]=10'h200 (-0), sign0[1]=1, delta0[1]=64, x[1]=16 -> w[5]=10'h010 (+16).
- Zero crossing: w=10'h010 (+16), sign 0, term 16 -> 10'h000, never 10'h200.
- Saturation: w=10'h3F4 (-500), delta0=1023, x=1023, sign 0 -> term clipped to 511, w=10'h3FF (-511). With HWU_SAT_CNT_EN, sat_count=1.
- Protocol: second start and wr_en=1 mid-RUN -> both ignored, single done pulse, bank matches the single-pass model. Write+start in the same IDLE cycle -> pass uses the new weight.
- Reset mid-pass: rst_n low at RUN index 7 -> busy=0, done never pulses, every rd_data read 10'h000 afterwards.
